// File: rtl/imgproc_conv3x3.sv
// imgproc_conv3x3 -- 3x3 neighbourhood filter for the camera pixel stream.
// Two line buffers plus a 3x3 window feed a two-stage pipeline. The kernel is
// chosen per pixel: passthrough, Gaussian blur, Sobel-X magnitude, or
// |Gx|+|Gy|. Each accepted pixel produces one result two cycles later.
// Optional feature: define IMGPROC_THRESH_EN to add iTHRESH. The two Sobel
// modes then output a binary map (all-ones when magnitude >= iTHRESH).
module imgproc_conv3x3 #(
   parameter int DATA_W  = 12,
   parameter int LINE_W  = 1280,
   parameter int COORD_W = 16
) (
   input  logic               iCLK,
   input  logic               iRST,
   input  logic [DATA_W-1:0]  iDATA,
   input  logic               iDVAL,
   input  logic [COORD_W-1:0] iX_Cont,
   input  logic [COORD_W-1:0] iY_Cont,
   input  logic [1:0]         iMODE,
`ifdef IMGPROC_THRESH_EN
   input  logic [DATA_W-1:0]  iTHRESH,
`endif
   output logic [DATA_W-1:0]  oDATA,
   output logic               oDVAL,
   output logic [COORD_W-1:0] oX_Cont,
   output logic [COORD_W-1:0] oY_Cont
);

   localparam int ADDR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam int ACC_W  = DATA_W + 4;
   localparam logic [COORD_W-1:0] LINE_LIMIT = COORD_W'(LINE_W);
   localparam logic [COORD_W-1:0] BORDER     = COORD_W'(2);

   typedef logic [DATA_W-1:0]       pix_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef enum logic [1:0] {
      MODE_PASS     = 2'd0,
      MODE_GAUSS    = 2'd1,
      MODE_SOBEL_X  = 2'd2,
      MODE_SOBEL_XY = 2'd3
   } mode_e;

   localparam acc_t PIX_MAX = acc_t'({4'b0000, {DATA_W{1'b1}}});

   // Zero-extend a pixel into the accumulator width.
   function automatic logic [ACC_W-1:0] ext(input pix_t p);
      return {4'b0000, p};
   endfunction

   // ---------------------------------------------------------------- line buffers
   pix_t              lb1_q [LINE_W];
   pix_t              lb2_q [LINE_W];
   logic              in_range;
   logic [ADDR_W-1:0] addr;
   pix_t              tap1;
   pix_t              tap2;

   assign in_range = (iX_Cont < LINE_LIMIT);
   assign addr     = iX_Cont[ADDR_W-1:0];
   // Out-of-range columns read as zero so the window never sees an illegal index.
   assign tap1     = in_range ? lb1_q[addr] : '0;
   assign tap2     = in_range ? lb2_q[addr] : '0;

   // Line buffers: push the current column one row up on each accepted in-range pixel.
   // NOTE: memories are not reset; stale rows are hidden by the border mask.
   always_ff @(posedge iCLK) begin
      if (iRST && iDVAL && in_range) begin
         lb1_q[addr] <= iDATA;
         lb2_q[addr] <= tap1;
      end
   end

   // ---------------------------------------------------------------- stage 1
   // win_q[col][row]: col 0 = oldest (left), row 0 = two rows back (top).
   pix_t                win_q [3][3];
   logic                s1_valid_q;
   logic                s1_oob_q;
   logic [COORD_W-1:0]  s1_x_q;
   logic [COORD_W-1:0]  s1_y_q;
   mode_e               s1_mode_q;

   // Stage 1: shift the window on accepted pixels and capture coordinates and mode.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
               win_q[c][r] <= '0;
            end
         end
         s1_valid_q <= 1'b0;
         s1_oob_q   <= 1'b0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_mode_q  <= MODE_PASS;
      end else begin
         s1_valid_q <= iDVAL;
         if (iDVAL) begin
            for (int r = 0; r < 3; r++) begin
               win_q[0][r] <= win_q[1][r];
               win_q[1][r] <= win_q[2][r];
            end
            win_q[2][0] <= tap2;
            win_q[2][1] <= tap1;
            win_q[2][2] <= iDATA;
            s1_oob_q    <= ~in_range;
            s1_x_q      <= iX_Cont;
            s1_y_q      <= iY_Cont;
            s1_mode_q   <= mode_e'(iMODE);
         end
      end
   end

   // ---------------------------------------------------------------- stage 2 math
   logic [ACC_W-1:0] gsum;
   acc_t             gx;
   acc_t             gy;
   acc_t             ax;
   acc_t             ay;
   acc_t             mag;
   pix_t             sat;
   pix_t             sobel;
   pix_t             result_d;
   logic             masked;

   // Kernel evaluation for the window held in stage 1.
   // NOTE: every output gets a default first so no latch is inferred.
   always_comb begin
      gsum     = '0;
      gx       = '0;
      gy       = '0;
      ax       = '0;
      ay       = '0;
      mag      = '0;
      sat      = '0;
      sobel    = '0;
      result_d = '0;

      // All Gaussian terms are non-negative, so the sum is kept unsigned; the
      // full-scale case (16 * max pixel) then fits without wrapping.
      gsum = ext(win_q[0][0]) + ext(win_q[2][0]) + ext(win_q[0][2]) + ext(win_q[2][2])
           + ((ext(win_q[1][0]) + ext(win_q[0][1]) + ext(win_q[2][1]) + ext(win_q[1][2])) << 1)
           + (ext(win_q[1][1]) << 2);

      gx = (acc_t'(ext(win_q[2][0])) + (acc_t'(ext(win_q[2][1])) <<< 1) + acc_t'(ext(win_q[2][2])))
         - (acc_t'(ext(win_q[0][0])) + (acc_t'(ext(win_q[0][1])) <<< 1) + acc_t'(ext(win_q[0][2])));
      gy = (acc_t'(ext(win_q[0][2])) + (acc_t'(ext(win_q[1][2])) <<< 1) + acc_t'(ext(win_q[2][2])))
         - (acc_t'(ext(win_q[0][0])) + (acc_t'(ext(win_q[1][0])) <<< 1) + acc_t'(ext(win_q[2][0])));

      ax  = gx[ACC_W-1] ? -gx : gx;
      ay  = gy[ACC_W-1] ? -gy : gy;
      mag = (s1_mode_q == MODE_SOBEL_XY) ? (ax + ay) : ax;
      sat = (mag > PIX_MAX) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];

`ifdef IMGPROC_THRESH_EN
      sobel = (sat >= iTHRESH) ? {DATA_W{1'b1}} : '0;
`else
      sobel = sat;
`endif

      case (s1_mode_q)
         MODE_PASS:  result_d = win_q[1][1];
         MODE_GAUSS: result_d = gsum[ACC_W-1:4];
         default:    result_d = sobel;
      endcase

      if (masked) begin
         result_d = '0;
      end
   end

   // Results centred on the first two rows/columns or on an out-of-range column are blanked.
   assign masked = s1_oob_q || (s1_x_q < BORDER) || (s1_y_q < BORDER);

   // ---------------------------------------------------------------- stage 2 registers
   // Stage 2: register the result and forward the delayed coordinates.
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         oDATA   <= '0;
         oDVAL   <= 1'b0;
         oX_Cont <= '0;
         oY_Cont <= '0;
      end else begin
         oDVAL <= s1_valid_q;
         if (s1_valid_q) begin
            oDATA   <= result_d;
            oX_Cont <= s1_x_q;
            oY_Cont <= s1_y_q;
         end
      end
   end

endmodule

// File: tb/tb_imgproc_conv3x3.sv
// tb_imgproc_conv3x3 -- scoreboard bench for imgproc_conv3x3 (LINE_W=8).
// Stimulus pushes the hand-derived expected result for each accepted pixel;
// a negedge monitor pops and compares whenever oDVAL is high, and a second
// check confirms oDVAL is iDVAL delayed by two cycles.
module tb_imgproc_conv3x3;

   localparam int DATA_W  = 12;
   localparam int LINE_W  = 8;
   localparam int COORD_W = 16;
   localparam int H       = 5;          // rows per frame
   localparam int XN      = LINE_W + 1; // one out-of-range column per row
   localparam int THRESH  = 200;

   typedef struct {
      logic [DATA_W-1:0]  d;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } exp_t;

   logic               iCLK = 1'b0;
   logic               iRST = 1'b0;
   logic [DATA_W-1:0]  iDATA = '0;
   logic               iDVAL = 1'b0;
   logic [COORD_W-1:0] iX_Cont = '0;
   logic [COORD_W-1:0] iY_Cont = '0;
   logic [1:0]         iMODE = '0;
`ifdef IMGPROC_THRESH_EN
   logic [DATA_W-1:0]  iTHRESH = DATA_W'(THRESH);
`endif
   logic [DATA_W-1:0]  oDATA;
   logic               oDVAL;
   logic [COORD_W-1:0] oX_Cont;
   logic [COORD_W-1:0] oY_Cont;

   exp_t sb_q [$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;
   logic started = 1'b0;
   logic dv_d1 = 1'b0;
   logic dv_d2 = 1'b0;

   imgproc_conv3x3 #(
      .DATA_W (DATA_W),
      .LINE_W (LINE_W),
      .COORD_W(COORD_W)
   ) dut (
      .iCLK   (iCLK),
      .iRST   (iRST),
      .iDATA  (iDATA),
      .iDVAL  (iDVAL),
      .iX_Cont(iX_Cont),
      .iY_Cont(iY_Cont),
      .iMODE  (iMODE),
`ifdef IMGPROC_THRESH_EN
      .iTHRESH(iTHRESH),
`endif
      .oDATA  (oDATA),
      .oDVAL  (oDVAL),
      .oX_Cont(oX_Cont),
      .oY_Cont(oY_Cont)
   );

   always #5 iCLK = ~iCLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame content. kind 0: {y[5:0],x[5:0]} ramp; 1: step 0->100 at x=4;
   // 2: step 0->4095 at x=4; 3: flat 1000; 4: flat 4095.
   function automatic int pix(input int kind, input int x, input int y);
      case (kind)
         0:       return (y % 64) * 64 + (x % 64);
         1:       return (x < 4) ? 0 : 100;
         2:       return (x < 4) ? 0 : 4095;
         3:       return 1000;
         default: return 4095;
      endcase
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Expected output for input pixel (x,y): the window is centred on (x-1,y-1).
   // Every frame has the same column difference on every row and the same row
   // difference on every column, so each Sobel sum is 4x a single difference.
   // The Gaussian of a linear or flat field equals its centre pixel; mode 1 is
   // only used on such frames.
   function automatic int expv(input int kind, input int mode, input int x, input int y);
      int c;
      int mag;
      if (x < 2 || y < 2 || x >= LINE_W) return 0;
      c = pix(kind, x - 1, y - 1);
      if (mode < 2) return c;
      mag = iabs(4 * (pix(kind, x, y) - pix(kind, x - 2, y)));
      if (mode == 3) mag += iabs(4 * (pix(kind, x - 1, y) - pix(kind, x - 1, y - 2)));
      if (mag > 4095) mag = 4095;
`ifdef IMGPROC_THRESH_EN
      mag = (mag >= THRESH) ? 4095 : 0;
`endif
      return mag;
   endfunction

   // Reference valid pipeline: two cycles of delay, cleared by reset.
   always @(posedge iCLK) begin
      started <= 1'b1;
      if (!iRST) begin
         dv_d1 <= 1'b0;
         dv_d2 <= 1'b0;
      end else begin
         dv_d1 <= iDVAL;
         dv_d2 <= dv_d1;
      end
   end

   // Monitor: valid timing every cycle, data/coordinates on each oDVAL.
   always @(negedge iCLK) begin
      if (started) check("odval_timing", 32'(oDVAL), 32'(dv_d2));
      if (oDVAL === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_output: got oDVAL=1 x=%0d y=%0d, expected none", oX_Cont, oY_Cont);
         end else begin
            mon_e = sb_q.pop_front();
            check("odata", 32'(oDATA), 32'(mon_e.d));
            check("ox",    32'(oX_Cont), 32'(mon_e.x));
            check("oy",    32'(oY_Cont), 32'(mon_e.y));
         end
      end
   end

   task automatic send(input int kind, input int mode, input int x, input int y);
      iDVAL   = 1'b1;
      iX_Cont = COORD_W'(x);
      iY_Cont = COORD_W'(y);
      iDATA   = DATA_W'(pix(kind, x, y));
      iMODE   = 2'(mode);
      @(posedge iCLK);
      if (iRST) sb_q.push_back('{DATA_W'(expv(kind, mode, x, y)), COORD_W'(x), COORD_W'(y)});
      #1;
   endtask

   task automatic idle();
      iDVAL = 1'b0;
      iDATA = DATA_W'($urandom);
      @(posedge iCLK);
      #1;
   endtask

   // mode < 0 rotates through all four modes pixel by pixel; stop_row >= 0
   // abandons the frame at column 3 of that row.
   task automatic run_frame(input int kind, input int mode, input bit stall, input int stop_row);
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < XN; x++) begin
            if (y == stop_row && x == 3) return;
            send(kind, (mode < 0) ? ((x + y) % 4) : mode, x, y);
            if (stall) idle();
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      iRST  = 1'b0;
      iDVAL = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         iDATA = DATA_W'($urandom);
         @(posedge iCLK);
         sb_q.delete();   // anything still in flight is flushed by reset
         #1;
         check("rst_odval", 32'(oDVAL), 32'd0);
         check("rst_odata", 32'(oDATA), 32'd0);
         check("rst_ox",    32'(oX_Cont), 32'd0);
         check("rst_oy",    32'(oY_Cont), 32'd0);
      end
      iDVAL = 1'b0;
      iRST  = 1'b1;
   endtask

   initial begin
      #1;
      do_reset(3);
      run_frame(0, 0, 1'b0, -1);  // passthrough: (5,3) -> 12'h084
      run_frame(0, -1, 1'b0, -1); // per-pixel mode changes
      run_frame(1, 2, 1'b0, -1);  // Sobel-X step: 400
      run_frame(1, 3, 1'b0, -1);  // |Gx|+|Gy| step: 400
      run_frame(2, 2, 1'b0, -1);  // saturation to 4095
      run_frame(2, 3, 1'b0, -1);
      run_frame(3, 1, 1'b0, -1);  // Gaussian flat 1000
      run_frame(4, 1, 1'b0, -1);  // Gaussian flat 4095
      run_frame(0, 0, 1'b1, -1);  // stalled passthrough
      run_frame(0, 0, 1'b0, 3);   // abandoned at row 3 by reset
      do_reset(2);
      run_frame(0, 0, 1'b0, -1);  // clean frame after reset
      iDVAL = 1'b0;
      for (int i = 0; i < 10 && sb_q.size() != 0; i++) begin
         @(posedge iCLK);
         #1;
      end
      check("drain", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
